// File: rtl/chan_fifo_writer_pkg.sv
// Shared definitions for the RX packet writer: state encodings, header bit
// positions (common with the TX reader) and the header packing helper.
package chan_fifo_writer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    WAITSPACE = 3'd2,
    HEADER    = 3'd3,
    TSTAMP    = 3'd4,
    FLUSH     = 3'd5
  } writer_state_t;

  localparam int SAMPLE_W     = 32;
  localparam int PKT_OVERHEAD = 2;

  localparam int PAYLOAD_HI   = 8;
  localparam int PAYLOAD_LO   = 2;
  localparam int OVERRUN      = 26;
  localparam int ENDOFBURST   = 27;
  localparam int STARTOFBURST = 28;
  localparam int CHANNEL_HI   = 24;
  localparam int CHANNEL_LO   = 21;
  localparam int RSSI_HI      = 16;
  localparam int RSSI_LO      = 9;

  // Sample count lands in [8:2] so that [8:0] reads as a byte count.
  function automatic logic [31:0] pack_header(
    input logic       sob,
    input logic       eob,
    input logic       ovr,
    input logic [3:0] chan,
    input logic [7:0] rssi_field,
    input logic [6:0] nsamp
  );
    logic [31:0] hdr;
    hdr                         = 32'd0;
    hdr[STARTOFBURST]           = sob;
    hdr[ENDOFBURST]             = eob;
    hdr[OVERRUN]                = ovr;
    hdr[CHANNEL_HI:CHANNEL_LO]  = chan;
    hdr[RSSI_HI:RSSI_LO]        = rssi_field;
    hdr[PAYLOAD_HI:PAYLOAD_LO]  = nsamp;
    return hdr;
  endfunction

endpackage

// File: rtl/chan_fifo_writer_rx_sample_buffer.sv
// Simple dual-port sample store for one packet: synchronous write,
// one-cycle registered read.
module rx_sample_buffer
  import chan_fifo_writer_pkg::*;
#(
  parameter int DEPTH = 126,
  parameter int AW    = 7
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Sample capture port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/chan_fifo_writer.sv
// RX packet framer: buffers strobed I/Q samples and writes header, timestamp
// and samples into the RX FIFO. Define RX_RSSI_HEADER_EN to report rssi[7:0].
module chan_fifo_writer
  import chan_fifo_writer_pkg::*;
#(
  parameter int         MAX_SAMPLES = 126,
  parameter logic [3:0] CHANNEL     = 4'd0
) (
  input  logic        rx_clock,
  input  logic        reset,
  input  logic        rx_strobe,
  input  logic [15:0] rx_i,
  input  logic [15:0] rx_q,
  input  logic        rx_enable,
  input  logic [31:0] timestamp_clock,
  input  logic [31:0] rssi,
  input  logic [8:0]  fifo_space,
  output logic [31:0] fifodata,
  output logic        wrreq,
  output logic        overrun,
  output logic [14:0] debug
);

  localparam logic [6:0] MAX_COUNT = 7'(MAX_SAMPLES);
  localparam logic [8:0] OVERHEAD  = 9'(PKT_OVERHEAD);

  writer_state_t state_r, state_s;

  logic [6:0]  count_r;
  logic [6:0]  flush_idx_r;
  logic [31:0] ts_r;
  logic        sob_r;
  logic        eob_r;
  logic        in_burst_r;
  logic        ovr_flag_r;

  logic        capture_s;
  logic        drop_s;
  logic        space_ok_s;
  logic [7:0]  rssi_field_s;
  logic [31:0] header_s;
  logic        buf_we_s;
  logic [6:0]  buf_waddr_s;
  logic [6:0]  buf_raddr_s;
  logic [31:0] buf_rdata_s;
  logic        wrreq_s;
  logic [31:0] fifodata_s;
  logic        unused_rssi;

`ifdef RX_RSSI_HEADER_EN
  assign rssi_field_s = rssi[7:0];
  assign unused_rssi  = ^rssi[31:8];
`else
  assign rssi_field_s = 8'd0;
  assign unused_rssi  = ^rssi;
`endif

  assign capture_s  = rx_enable && rx_strobe;
  assign space_ok_s = fifo_space >= ({2'b00, count_r} + OVERHEAD);
  assign drop_s     = capture_s && (state_r == WAITSPACE || state_r == HEADER ||
                                    state_r == TSTAMP    || state_r == FLUSH);
  assign header_s   = pack_header(sob_r, eob_r, ovr_flag_r, CHANNEL, rssi_field_s, count_r);

  rx_sample_buffer #(
    .DEPTH (MAX_SAMPLES),
    .AW    (7)
  ) u_buf (
    .clk     (rx_clock),
    .wr_en   (buf_we_s),
    .wr_addr (buf_waddr_s),
    .wr_data ({rx_q, rx_i}),
    .rd_addr (buf_raddr_s),
    .rd_data (buf_rdata_s)
  );

  // State register
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_s = (MAX_SAMPLES <= 1) ? WAITSPACE : FILL;
        end else if (!rx_enable && in_burst_r) begin
          state_s = WAITSPACE;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (!rx_enable) begin
          state_s = WAITSPACE;
        end else if (rx_strobe && ((count_r + 7'd1) >= MAX_COUNT)) begin
          state_s = WAITSPACE;
        end else begin
          state_s = FILL;
        end
      end
      WAITSPACE: begin
        if (space_ok_s) begin
          state_s = HEADER;
        end else begin
          state_s = WAITSPACE;
        end
      end
      HEADER: state_s = TSTAMP;
      TSTAMP: begin
        if (count_r == 7'd0) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_idx_r == (count_r - 7'd1)) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output and buffer-port decode; FLUSH prefetches the next read address
  always_comb begin
    wrreq_s     = 1'b0;
    fifodata_s  = 32'd0;
    buf_we_s    = 1'b0;
    buf_waddr_s = 7'd0;
    buf_raddr_s = 7'd0;
    case (state_r)
      IDLE: begin
        buf_we_s    = capture_s;
        buf_waddr_s = 7'd0;
      end
      FILL: begin
        buf_we_s    = capture_s;
        buf_waddr_s = count_r;
      end
      HEADER: begin
        wrreq_s    = 1'b1;
        fifodata_s = header_s;
      end
      TSTAMP: begin
        wrreq_s     = 1'b1;
        fifodata_s  = ts_r;
        buf_raddr_s = 7'd0;
      end
      FLUSH: begin
        wrreq_s    = 1'b1;
        fifodata_s = buf_rdata_s;
        if ((flush_idx_r + 7'd1) < count_r) begin
          buf_raddr_s = flush_idx_r + 7'd1;
        end else begin
          buf_raddr_s = flush_idx_r;
        end
      end
      default: begin
        wrreq_s = 1'b0;
      end
    endcase
  end

  // Packet bookkeeping: count, timestamp, burst flags and overrun flag
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      count_r     <= 7'd0;
      flush_idx_r <= 7'd0;
      ts_r        <= 32'd0;
      sob_r       <= 1'b0;
      eob_r       <= 1'b0;
      in_burst_r  <= 1'b0;
      ovr_flag_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            count_r <= 7'd1;
            ts_r    <= timestamp_clock;
            sob_r   <= !in_burst_r;
            eob_r   <= 1'b0;
          end else if (!rx_enable && in_burst_r) begin
            count_r <= 7'd0;
            ts_r    <= timestamp_clock;
            sob_r   <= 1'b0;
            eob_r   <= 1'b1;
          end
        end
        FILL: begin
          if (!rx_enable) begin
            eob_r <= 1'b1;
          end else if (rx_strobe && (count_r < MAX_COUNT)) begin
            count_r <= count_r + 7'd1;
            eob_r   <= 1'b0;
          end
        end
        HEADER:  in_burst_r  <= !eob_r;
        TSTAMP:  flush_idx_r <= 7'd0;
        FLUSH:   flush_idx_r <= flush_idx_r + 7'd1;
        default: flush_idx_r <= flush_idx_r;
      endcase
      // A drop in the HEADER cycle belongs to the next packet, so set wins
      if (drop_s) begin
        ovr_flag_r <= 1'b1;
      end else if (state_r == HEADER) begin
        ovr_flag_r <= 1'b0;
      end
    end
  end

  // Registered FIFO-side outputs
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      fifodata <= 32'd0;
      wrreq    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      fifodata <= fifodata_s;
      wrreq    <= wrreq_s;
      overrun  <= drop_s;
    end
  end

  assign debug = {7'd0, wrreq, overrun, state_r, rx_enable, rx_strobe, rx_clock};

endmodule

// File: tb/tb_chan_fifo_writer.sv
// Scoreboard bench for chan_fifo_writer: expected FIFO words are queued by the
// stimulus process and checked by an independent monitor on every wrreq.
module tb_chan_fifo_writer;

  localparam logic [3:0] CH = 4'd5;
`ifdef RX_RSSI_HEADER_EN
  localparam logic [7:0] RSSI_EXP = 8'h3A;
`else
  localparam logic [7:0] RSSI_EXP = 8'h00;
`endif

  logic        clk;
  logic        reset;
  logic        rx_strobe;
  logic [15:0] rx_i;
  logic [15:0] rx_q;
  logic        rx_enable;
  logic [31:0] timestamp_clock;
  logic [31:0] rssi;
  logic [8:0]  fifo_space;
  logic [31:0] fifodata;
  logic        wrreq;
  logic        overrun;
  logic [14:0] debug;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cur_samples[$];

  int total = 0;
  int bad   = 0;
  int writes_seen = 0;
  int ovr_seen = 0;
  int exp_ovr = 0;
  int stall = 0;
  bit mid_pkt = 1'b0;
  bit chk_idle = 1'b0;
  bit quiet = 1'b0;
  bit ovr_chk = 1'b0;

  chan_fifo_writer #(
    .MAX_SAMPLES (126),
    .CHANNEL     (CH)
  ) dut (
    .rx_clock        (clk),
    .reset           (reset),
    .rx_strobe       (rx_strobe),
    .rx_i            (rx_i),
    .rx_q            (rx_q),
    .rx_enable       (rx_enable),
    .timestamp_clock (timestamp_clock),
    .rssi            (rssi),
    .fifo_space      (fifo_space),
    .fifodata        (fifodata),
    .wrreq           (wrreq),
    .overrun         (overrun),
    .debug           (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_hdr(input bit sob, input bit eob, input bit ovr, input int n);
    logic [31:0] h;
    h        = 32'd0;
    h[28]    = sob;
    h[27]    = eob;
    h[26]    = ovr;
    h[24:21] = CH;
    h[16:9]  = RSSI_EXP;
    h[8:0]   = 9'(n * 4);
    return h;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: samples 1ns after the falling edge, well away from rx_clock rising
  always @(negedge clk) begin
    #1;
    if (reset) begin
      mid_pkt = 1'b0;
    end else begin
      if (overrun === 1'b1) ovr_seen++;
      if (wrreq === 1'b1) begin
        writes_seen++;
        stall = 0;
        if (exp_q.size() == 0) begin
          cmp("unexpected_write", fifodata, 32'hxxxx_xxxx);
          mid_pkt = 1'b0;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          cmp("fifo_word", fifodata, e.data);
          mid_pkt = !e.last;
        end
      end else begin
        if (mid_pkt) begin
          cmp("wrreq_gap", {31'd0, wrreq}, 32'd1);
          mid_pkt = 1'b0;
        end
        if (exp_q.size() != 0) begin
          stall++;
          if (stall > 400) begin
            cmp("drain_timeout_words_left", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            stall = 0;
          end
        end
      end
      if (quiet) cmp("quiet_wrreq", {31'd0, wrreq}, 32'd0);
      if (chk_idle) begin
        cmp("idle_wrreq", {31'd0, wrreq}, 32'd0);
        cmp("idle_fifodata", fifodata, 32'd0);
        cmp("idle_overrun", {31'd0, overrun}, 32'd0);
        cmp("idle_state", {29'd0, debug[5:3]}, {29'd0, chan_fifo_writer_pkg::IDLE});
      end
      if (ovr_chk) cmp("overrun_pulses", 32'(ovr_seen), 32'(exp_ovr));
    end
  end

  task automatic strobe(input logic [15:0] i, input logic [15:0] q, input bit keep);
    rx_i      = i;
    rx_q      = q;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
    @(negedge clk);
    if (keep) cur_samples.push_back({q, i});
  endtask

  task automatic push_packet(input bit sob, input bit eob, input bit ovr, input logic [31:0] ts);
    exp_t e;
    int   n;
    n = cur_samples.size();
    e.data = exp_hdr(sob, eob, ovr, n);
    e.last = 1'b0;
    exp_q.push_back(e);
    e.data = ts;
    e.last = (n == 0);
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      e.data = cur_samples[k];
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
    cur_samples.delete();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_ovr(input int expected);
    exp_ovr = expected;
    ovr_chk = 1'b1;
    @(negedge clk);
    ovr_chk = 1'b0;
  endtask

  initial begin
    int w0;
    reset           = 1'b1;
    rx_strobe       = 1'b0;
    rx_i            = 16'd0;
    rx_q            = 16'd0;
    rx_enable       = 1'b0;
    timestamp_clock = 32'd0;
    rssi            = 32'hFFFF_FF3A;
    fifo_space      = 9'd256;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    chk_idle = 1'b1;
    @(negedge clk);
    chk_idle = 1'b0;

    // Single 3-sample burst
    rx_enable       = 1'b1;
    timestamp_clock = 32'd100;
    for (int k = 1; k <= 3; k++) strobe(16'(k), 16'(16'h0010 + k - 1), 1'b1);
    push_packet(1'b1, 1'b1, 1'b0, 32'd100);
    rx_enable = 1'b0;
    wait_drain();
    check_ovr(0);

    // 130-sample burst: full packet, three drops during the flush, 4-sample tail
    rx_enable       = 1'b1;
    timestamp_clock = 32'd200;
    for (int k = 1; k <= 126; k++) strobe(16'(k), 16'(16'h8000 + k), 1'b1);
    push_packet(1'b1, 1'b0, 1'b0, 32'd200);
    for (int k = 0; k < 3; k++) strobe(16'hDEAD, 16'hBEEF, 1'b0);
    wait_drain();
    timestamp_clock = 32'd300;
    for (int k = 127; k <= 130; k++) strobe(16'(k), 16'(16'h8000 + k), 1'b1);
    push_packet(1'b0, 1'b1, 1'b1, 32'd300);
    rx_enable = 1'b0;
    wait_drain();
    check_ovr(3);

    // Exactly 126 samples, then a header+timestamp end-of-burst packet
    rx_enable       = 1'b1;
    timestamp_clock = 32'd400;
    for (int k = 1; k <= 126; k++) strobe(16'(16'h0200 + k), 16'(16'hA000 + k), 1'b1);
    push_packet(1'b1, 1'b0, 1'b0, 32'd400);
    rx_enable       = 1'b0;
    timestamp_clock = 32'd450;
    push_packet(1'b0, 1'b1, 1'b0, 32'd450);
    wait_drain();
    check_ovr(3);

    // Backpressure: 10 samples wait for 12 free words; drops while waiting
    fifo_space      = 9'd4;
    rx_enable       = 1'b1;
    timestamp_clock = 32'd500;
    for (int k = 1; k <= 10; k++) strobe(16'(16'h0300 + k), 16'(16'hB000 + k), 1'b1);
    rx_enable = 1'b0;
    @(negedge clk);
    rx_enable = 1'b1;
    quiet     = 1'b1;
    for (int k = 0; k < 3; k++) strobe(16'h1111, 16'h2222, 1'b0);
    repeat (4) @(negedge clk);
    fifo_space = 9'd11;
    repeat (4) @(negedge clk);
    quiet = 1'b0;
    push_packet(1'b1, 1'b1, 1'b1, 32'd500);
    fifo_space = 9'd12;
    wait_drain();
    check_ovr(6);
    rx_enable  = 1'b0;
    fifo_space = 9'd256;
    repeat (2) @(negedge clk);

    // Reset during the flush of a mid-burst packet
    rx_enable       = 1'b1;
    timestamp_clock = 32'd600;
    for (int k = 1; k <= 126; k++) strobe(16'(16'h0400 + k), 16'(16'hC000 + k), 1'b1);
    w0 = writes_seen;
    push_packet(1'b1, 1'b0, 1'b0, 32'd600);
    rx_enable = 1'b0;
    for (int k = 0; k < 200 && writes_seen < w0 + 7; k++) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset    = 1'b0;
    chk_idle = 1'b1;
    quiet    = 1'b1;
    @(negedge clk);
    chk_idle = 1'b0;
    repeat (20) @(negedge clk);
    quiet = 1'b0;

    // Fresh burst after reset starts a new burst with a new timestamp
    rx_enable       = 1'b1;
    timestamp_clock = 32'd700;
    strobe(16'h0501, 16'hD001, 1'b1);
    strobe(16'h0502, 16'hD002, 1'b1);
    push_packet(1'b1, 1'b1, 1'b0, 32'd700);
    rx_enable = 1'b0;
    wait_drain();
    check_ovr(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

endmodule
